// File: rtl/cam_pkg.sv
// Shared types and pixel-format conversion for the FIFO camera capture block.
package cam_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        WRITE,
        RRST,
        RD_HI,
        RD_LO,
        DONE
    } cam_state_e;

    localparam logic FMT_RGB333 = 1'b0;
    localparam logic FMT_GRAY   = 1'b1;
    localparam int   PIX_W_MIN  = 9;

    // Both formats fit in 9 bits; callers zero-extend to their stored width.
    function automatic logic [PIX_W_MIN-1:0] pix_convert(input logic [15:0] p565,
                                                         input logic        fmt);
        logic [6:0]           gray;
        logic [PIX_W_MIN-1:0] result;
        gray = 7'(p565[15:11]) + 7'(p565[10:5]) + 7'(p565[4:0]);
        if (fmt == FMT_GRAY) begin
            result = {2'b00, gray};
        end else begin
            result = {p565[15:13], p565[10:8], p565[4:2]};
        end
        return result;
    endfunction

endpackage

// File: rtl/cam_fifo_capture_if.sv
// AL422B-style FIFO bus: read data byte plus the controller-driven FIFO strobes.
interface cam_fifo_capture_if;
    logic [7:0] cam_data;
    logic       fifo_rclk_en;
    logic       fifo_rrst;
    logic       fifo_wrst;
    logic       fifo_wen;
    logic       fifo_oe;

    modport master (
        input  cam_data,
        output fifo_rclk_en, fifo_rrst, fifo_wrst, fifo_wen, fifo_oe
    );

    modport slave (
        output cam_data,
        input  fifo_rclk_en, fifo_rrst, fifo_wrst, fifo_wen, fifo_oe
    );
endinterface

// File: rtl/cam_fb_ram.sv
// Simple dual-port frame buffer: one write port, one registered read port (read-before-write).
module cam_fb_ram #(
    parameter int AW    = 15,
    parameter int PIX_W = 9
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [PIX_W-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [PIX_W-1:0] rdata
);

    logic [PIX_W-1:0] mem [1 << AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/cam_fifo_capture.sv
// FIFO camera controller: arms one frame into the FIFO on VSYNC, reads it back,
// converts RGB565, downsamples and stores it in the internal frame buffer.
module cam_fifo_capture
    import cam_pkg::*;
#(
    parameter int CAM_W   = 320,
    parameter int CAM_H   = 240,
    parameter int DS_LOG2 = 1,
    parameter int PIX_W   = 9,
    parameter int AW      = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    cam_fifo_capture_if.master  fifo,
    input  logic                ov_vsync,
    input  logic                start,
    input  logic                continuous,
    input  logic                fmt_sel,
    output logic                busy,
    output logic                frame_done,
    output logic [15:0]         frame_cnt,
    input  logic [AW-1:0]       rd_addr,
    output logic [PIX_W-1:0]    rd_data
);

    localparam int OUT_W = CAM_W >> DS_LOG2;
    localparam int OUT_H = CAM_H >> DS_LOG2;
    localparam int DEPTH = OUT_W * OUT_H;
    localparam int XW    = $clog2(CAM_W);
    localparam int YW    = $clog2(CAM_H);
    localparam logic [XW-1:0] DS_XMASK = XW'((1 << DS_LOG2) - 1);
    localparam logic [YW-1:0] DS_YMASK = YW'((1 << DS_LOG2) - 1);

    cam_state_e       state_reg;
    logic             vs_meta_reg, vs_sync_reg, vs_prev_reg;
    logic [XW-1:0]    x_reg;
    logic [YW-1:0]    y_reg;
    logic [7:0]       hi_reg;
    logic             fmt_reg;
    logic             rrst_cnt_reg;
    logic             wen_reg, wrst_reg, rrst_reg, rclk_en_reg;
    logic             busy_reg, done_reg;
    logic [15:0]      cnt_reg;
    logic             rd_valid_reg;

    logic             vs_rise;
    logic             last_x, last_y;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [PIX_W-1:0] wr_data;
    logic [PIX_W-1:0] ram_q;

    assign vs_rise = vs_sync_reg & ~vs_prev_reg;
    assign last_x  = (x_reg == XW'(CAM_W - 1));
    assign last_y  = (y_reg == YW'(CAM_H - 1));

    // Only the top-left sensor pixel of each 2^DS_LOG2 square is kept.
    assign wr_en   = (state_reg == RD_LO) && ((x_reg & DS_XMASK) == '0) && ((y_reg & DS_YMASK) == '0);
    assign wr_addr = AW'(32'(y_reg >> DS_LOG2) * 32'(OUT_W) + 32'(x_reg >> DS_LOG2));
    assign wr_data = PIX_W'(pix_convert({hi_reg, fifo.cam_data}, fmt_reg));

    cam_fb_ram #(
        .AW    (AW),
        .PIX_W (PIX_W)
    ) u_fb_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_addr),
        .wdata (wr_data),
        .raddr (rd_addr),
        .rdata (ram_q)
    );

    assign rd_data           = rd_valid_reg ? ram_q : '0;
    assign busy              = busy_reg;
    assign frame_done        = done_reg;
    assign frame_cnt         = cnt_reg;
    assign fifo.fifo_wen     = wen_reg;
    assign fifo.fifo_wrst    = wrst_reg;
    assign fifo.fifo_rrst    = rrst_reg;
    assign fifo.fifo_rclk_en = rclk_en_reg;
    assign fifo.fifo_oe      = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            vs_meta_reg  <= 1'b0;
            vs_sync_reg  <= 1'b0;
            vs_prev_reg  <= 1'b0;
            x_reg        <= '0;
            y_reg        <= '0;
            hi_reg       <= '0;
            fmt_reg      <= FMT_RGB333;
            rrst_cnt_reg <= 1'b0;
            wen_reg      <= 1'b0;
            wrst_reg     <= 1'b1;
            rrst_reg     <= 1'b1;
            rclk_en_reg  <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            cnt_reg      <= '0;
            rd_valid_reg <= 1'b0;
        end else begin
            vs_meta_reg  <= ov_vsync;
            vs_sync_reg  <= vs_meta_reg;
            vs_prev_reg  <= vs_sync_reg;
            rd_valid_reg <= (32'(rd_addr) < 32'(DEPTH));

            case (state_reg)
                IDLE: begin
                    if (start) begin
                        fmt_reg   <= fmt_sel;
                        busy_reg  <= 1'b1;
                        state_reg <= ARM;
                    end
                end
                ARM: begin
                    if (vs_rise) begin
                        wen_reg   <= 1'b1;
                        wrst_reg  <= 1'b0;
                        state_reg <= WRITE;
                    end
                end
                WRITE: begin
                    wrst_reg <= 1'b1;
                    // Second VSYNC closes the write window: the FIFO holds one full frame.
                    if (vs_rise) begin
                        wen_reg      <= 1'b0;
                        rclk_en_reg  <= 1'b1;
                        rrst_reg     <= 1'b0;
                        rrst_cnt_reg <= 1'b0;
                        state_reg    <= RRST;
                    end
                end
                RRST: begin
                    if (rrst_cnt_reg) begin
                        rrst_reg  <= 1'b1;
                        x_reg     <= '0;
                        y_reg     <= '0;
                        state_reg <= RD_HI;
                    end else begin
                        rrst_cnt_reg <= 1'b1;
                    end
                end
                RD_HI: begin
                    hi_reg    <= fifo.cam_data;
                    state_reg <= RD_LO;
                end
                RD_LO: begin
                    if (last_x && last_y) begin
                        rclk_en_reg <= 1'b0;
                        done_reg    <= 1'b1;
                        cnt_reg     <= cnt_reg + 16'd1;
                        state_reg   <= DONE;
                    end else begin
                        if (last_x) begin
                            x_reg <= '0;
                            y_reg <= y_reg + YW'(1);
                        end else begin
                            x_reg <= x_reg + XW'(1);
                        end
                        state_reg <= RD_HI;
                    end
                end
                DONE: begin
                    done_reg <= 1'b0;
                    if (continuous) begin
                        fmt_reg   <= fmt_sel;
                        state_reg <= ARM;
                    end else begin
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cam_fifo_capture.sv
// Bench for cam_fifo_capture on a reduced 16x8 sensor with an AL422B read-side model.
module tb_cam_fifo_capture;

    localparam int CAM_W   = 16;
    localparam int CAM_H   = 8;
    localparam int DS_LOG2 = 1;
    localparam int PIX_W   = 9;
    localparam int AW      = 6;
    localparam int OUT_W   = CAM_W >> DS_LOG2;
    localparam int OUT_H   = CAM_H >> DS_LOG2;
    localparam int OUT_N   = OUT_W * OUT_H;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             ov_vsync = 1'b0;
    logic             start = 1'b0;
    logic             continuous = 1'b0;
    logic             fmt_sel = 1'b0;
    logic             busy;
    logic             frame_done;
    logic [15:0]      frame_cnt;
    logic [AW-1:0]    rd_addr = '0;
    logic [PIX_W-1:0] rd_data;

    int checks = 0;
    int failures = 0;
    int pattern = 0;
    int rp = 0;
    int wrst_low_n = 0;
    int rrst_low_n = 0;
    int done_n = 0;
    logic [PIX_W-1:0] exp_q[$];

    cam_fifo_capture_if fif();

    cam_fifo_capture #(
        .CAM_W   (CAM_W),
        .CAM_H   (CAM_H),
        .DS_LOG2 (DS_LOG2),
        .PIX_W   (PIX_W),
        .AW      (AW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fifo       (fif),
        .ov_vsync   (ov_vsync),
        .start      (start),
        .continuous (continuous),
        .fmt_sel    (fmt_sel),
        .busy       (busy),
        .frame_done (frame_done),
        .frame_cnt  (frame_cnt),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] src_pix(input int pat, input int idx);
        logic [15:0] p;
        case (pat)
            0:       p = 16'(idx);
            1:       p = 16'hFFFF;
            default: p = 16'(idx * 40503) ^ 16'h5A3C;
        endcase
        return p;
    endfunction

    function automatic logic [7:0] src_byte(input int pat, input int b);
        logic [15:0] p;
        p = src_pix(pat, b / 2);
        return (b % 2 == 0) ? p[15:8] : p[7:0];
    endfunction

    function automatic logic [PIX_W-1:0] model_pix(input int pat, input bit fmt, input int a);
        logic [15:0] p;
        int ox, oy, idx, s;
        if (a >= OUT_N) return '0;
        ox  = a % OUT_W;
        oy  = a / OUT_W;
        idx = (oy << DS_LOG2) * CAM_W + (ox << DS_LOG2);
        p   = src_pix(pat, idx);
        if (fmt) begin
            s = int'(p[15:11]) + int'(p[10:5]) + int'(p[4:0]);
            return PIX_W'(s);
        end
        return PIX_W'({p[15:13], p[10:8], p[4:2]});
    endfunction

    // FIFO read side: pointer cleared while rrst is low, advances on every enabled read clock.
    always @(posedge clk) begin
        if (fif.fifo_rclk_en) begin
            if (!fif.fifo_rrst) rp <= 0;
            else                rp <= rp + 1;
        end
    end
    assign fif.cam_data = src_byte(pattern, rp);

    always @(negedge clk) begin
        if (!fif.fifo_wrst) wrst_low_n <= wrst_low_n + 1;
        if (!fif.fifo_rrst) rrst_low_n <= rrst_low_n + 1;
        if (frame_done)     done_n     <= done_n + 1;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_vsync();
        ov_vsync = 1'b1;
        cyc(3);
        ov_vsync = 1'b0;
        cyc(4);
    endtask

    task automatic kick_start();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    task automatic wait_done(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (frame_done) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cyc(2);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", frame_done); end
        checks++; if (frame_cnt !== 16'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", frame_cnt); end
        checks++; if (fif.fifo_wen !== 1'b0) begin failures++; $display("FAIL reset_wen got=%0b exp=0", fif.fifo_wen); end
        checks++; if (fif.fifo_wrst !== 1'b1) begin failures++; $display("FAIL reset_wrst got=%0b exp=1", fif.fifo_wrst); end
        checks++; if (fif.fifo_rrst !== 1'b1) begin failures++; $display("FAIL reset_rrst got=%0b exp=1", fif.fifo_rrst); end
        checks++; if (fif.fifo_rclk_en !== 1'b0) begin failures++; $display("FAIL reset_rclk_en got=%0b exp=0", fif.fifo_rclk_en); end
        checks++; if (fif.fifo_oe !== 1'b0) begin failures++; $display("FAIL reset_oe got=%0b exp=0", fif.fifo_oe); end
        checks++; if (rd_data !== '0) begin failures++; $display("FAIL reset_rd_data got=%0h exp=0", rd_data); end
        rst_n = 1'b1;
        cyc(2);
        $display("test_reset done");
    endtask

    task automatic test_single_frame();
        bit seen;
        int w0, r0, d0;
        pattern = 0; fmt_sel = 1'b0; continuous = 1'b0;
        kick_start();
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy_arm got=%0b exp=1", busy); end
        checks++; if (fif.fifo_wen !== 1'b0) begin failures++; $display("FAIL single_wen_arm got=%0b exp=0", fif.fifo_wen); end
        w0 = wrst_low_n;
        pulse_vsync();
        checks++; if (fif.fifo_wen !== 1'b1) begin failures++; $display("FAIL single_wen_write got=%0b exp=1", fif.fifo_wen); end
        checks++; if (wrst_low_n - w0 !== 1) begin failures++; $display("FAIL single_wrst_cycles got=%0d exp=1", wrst_low_n - w0); end
        r0 = rrst_low_n; d0 = done_n;
        pulse_vsync();
        checks++; if (fif.fifo_wen !== 1'b0) begin failures++; $display("FAIL single_wen_closed got=%0b exp=0", fif.fifo_wen); end
        wait_done(seen);
        checks++; if (seen !== 1'b1) begin failures++; $display("FAIL single_done_timeout got=%0b exp=1", seen); end
        checks++; if (frame_cnt !== 16'd1) begin failures++; $display("FAIL single_cnt got=%0d exp=1", frame_cnt); end
        cyc(2);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_idle got=%0b exp=0", busy); end
        checks++; if (fif.fifo_rclk_en !== 1'b0) begin failures++; $display("FAIL single_rclk_off got=%0b exp=0", fif.fifo_rclk_en); end
        checks++; if (done_n - d0 !== 1) begin failures++; $display("FAIL single_done_pulses got=%0d exp=1", done_n - d0); end
        checks++; if (rrst_low_n - r0 !== 2) begin failures++; $display("FAIL single_rrst_cycles got=%0d exp=2", rrst_low_n - r0); end
        $display("test_single_frame done frame_cnt=%0d", frame_cnt);
    endtask

    task automatic test_readback(input int pat, input bit fmt, input string tag);
        logic [PIX_W-1:0] e;
        int a;
        for (int i = 0; i <= OUT_N + 1; i++) begin
            a = (i == OUT_N + 1) ? (1 << AW) - 1 : i;
            rd_addr = AW'(a);
            exp_q.push_back(model_pix(pat, fmt, a));
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (rd_data !== e) begin
                failures++;
                $display("FAIL readback_%s addr=%0d got=%0h exp=%0h", tag, a, rd_data, e);
            end
        end
        $display("test_readback %s done", tag);
    endtask

    task automatic test_gray();
        bit seen;
        pattern = 1; fmt_sel = 1'b1; continuous = 1'b0;
        kick_start();
        fmt_sel = 1'b0;
        pulse_vsync();
        pulse_vsync();
        wait_done(seen);
        checks++; if (seen !== 1'b1) begin failures++; $display("FAIL gray_done_timeout got=%0b exp=1", seen); end
        checks++; if (frame_cnt !== 16'd2) begin failures++; $display("FAIL gray_cnt got=%0d exp=2", frame_cnt); end
        cyc(2);
        $display("test_gray done frame_cnt=%0d", frame_cnt);
    endtask

    task automatic test_continuous();
        bit seen;
        int d0;
        rst_n = 1'b0; cyc(2); rst_n = 1'b1; cyc(2);
        pattern = 2; fmt_sel = 1'b0; continuous = 1'b1;
        d0 = done_n;
        kick_start();
        for (int f = 0; f < 3; f++) begin
            if (f == 2) continuous = 1'b0;
            pulse_vsync();
            checks++; if (fif.fifo_wen !== 1'b1) begin failures++; $display("FAIL cont_wen_frame%0d got=%0b exp=1", f, fif.fifo_wen); end
            pulse_vsync();
            cyc(20);
            pulse_vsync();
            wait_done(seen);
            checks++; if (seen !== 1'b1) begin failures++; $display("FAIL cont_done_timeout_frame%0d got=%0b exp=1", f, seen); end
            cyc(2);
            checks++; if (busy !== (f < 2)) begin failures++; $display("FAIL cont_busy_frame%0d got=%0b exp=%0b", f, busy, f < 2); end
        end
        checks++; if (frame_cnt !== 16'd3) begin failures++; $display("FAIL cont_cnt got=%0d exp=3", frame_cnt); end
        checks++; if (done_n - d0 !== 3) begin failures++; $display("FAIL cont_done_pulses got=%0d exp=3", done_n - d0); end
        $display("test_continuous done frame_cnt=%0d", frame_cnt);
    endtask

    task automatic test_reset_mid_frame();
        bit seen;
        pattern = 0; fmt_sel = 1'b1; continuous = 1'b0;
        rd_addr = AW'(5);
        kick_start();
        pulse_vsync();
        pulse_vsync();
        cyc(60);
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%0b exp=0", busy); end
        checks++; if (frame_cnt !== 16'd0) begin failures++; $display("FAIL midrst_cnt got=%0d exp=0", frame_cnt); end
        checks++; if (fif.fifo_rclk_en !== 1'b0) begin failures++; $display("FAIL midrst_rclk_en got=%0b exp=0", fif.fifo_rclk_en); end
        checks++; if (fif.fifo_rrst !== 1'b1) begin failures++; $display("FAIL midrst_rrst got=%0b exp=1", fif.fifo_rrst); end
        checks++; if (fif.fifo_wen !== 1'b0) begin failures++; $display("FAIL midrst_wen got=%0b exp=0", fif.fifo_wen); end
        checks++; if (rd_data !== '0) begin failures++; $display("FAIL midrst_rd_data got=%0h exp=0", rd_data); end
        cyc(2);
        rst_n = 1'b1;
        cyc(2);
        pattern = 2;
        kick_start();
        pulse_vsync();
        pulse_vsync();
        wait_done(seen);
        checks++; if (seen !== 1'b1) begin failures++; $display("FAIL midrst_done_timeout got=%0b exp=1", seen); end
        checks++; if (frame_cnt !== 16'd1) begin failures++; $display("FAIL midrst_cnt_after got=%0d exp=1", frame_cnt); end
        cyc(2);
        $display("test_reset_mid_frame done frame_cnt=%0d", frame_cnt);
    endtask

    task automatic test_start_toggle();
        bit seen;
        int d0;
        pattern = 1; fmt_sel = 1'b0; continuous = 1'b0;
        d0 = done_n;
        kick_start();
        pulse_vsync();
        for (int i = 0; i < 6; i++) begin start = ~start; cyc(1); end
        start = 1'b0;
        checks++; if (fif.fifo_wen !== 1'b1) begin failures++; $display("FAIL toggle_wen_write got=%0b exp=1", fif.fifo_wen); end
        pulse_vsync();
        cyc(10);
        for (int i = 0; i < 10; i++) begin start = ~start; cyc(1); end
        start = 1'b0;
        wait_done(seen);
        checks++; if (seen !== 1'b1) begin failures++; $display("FAIL toggle_done_timeout got=%0b exp=1", seen); end
        cyc(20);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL toggle_busy got=%0b exp=0", busy); end
        checks++; if (fif.fifo_wen !== 1'b0) begin failures++; $display("FAIL toggle_wen_idle got=%0b exp=0", fif.fifo_wen); end
        checks++; if (done_n - d0 !== 1) begin failures++; $display("FAIL toggle_done_pulses got=%0d exp=1", done_n - d0); end
        checks++; if (frame_cnt !== 16'd2) begin failures++; $display("FAIL toggle_cnt got=%0d exp=2", frame_cnt); end
        $display("test_start_toggle done frame_cnt=%0d", frame_cnt);
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_readback(0, 1'b0, "single");
        test_gray();
        test_readback(1, 1'b1, "gray");
        test_continuous();
        test_readback(2, 1'b0, "cont");
        test_reset_mid_frame();
        test_readback(2, 1'b1, "midrst");
        test_start_toggle();
        test_readback(1, 1'b0, "toggle");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
